ibex_csr_staged: RTL and testbench



---
 rtl/ibex_csr_staged_if.sv | 36 +++
 rtl/ibex_csr_staged.sv | 140 ++++++++++++++
 tb/tb_ibex_csr_staged.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ibex_csr_staged_if.sv
// ============================================================================
// Module      : ibex_csr_staged_if
// Description : Write-request / status bundle between the CSR write decode and
//               one protected CSR instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ibex_csr_staged_if #(
    parameter int unsigned Width = 32
) ();
    logic             wr_en_i;
    logic [1:0]       wr_op_i;
    logic [Width-1:0] wr_data_i;
    logic             abort_i;
    logic             lock_i;
    logic [Width-1:0] rd_data_o;
    logic             staged_o;
    logic             locked_o;
    logic             commit_o;
    logic             update_err_o;
    logic             rd_error_o;

    // Decode side drives requests and observes status.
    modport master (
        output wr_en_i, wr_op_i, wr_data_i, abort_i, lock_i,
        input  rd_data_o, staged_o, locked_o, commit_o, update_err_o, rd_error_o
    );

    modport slave (
        input  wr_en_i, wr_op_i, wr_data_i, abort_i, lock_i,
        output rd_data_o, staged_o, locked_o, commit_o, update_err_o, rd_error_o
    );
endinterface

`default_nettype wire

// File: rtl/ibex_csr_staged.sv
// ============================================================================
// Module      : ibex_csr_staged
// Description : Protected CSR with WARL mask, optional stage-then-confirm
//               writes, sticky lock and inverted shadow integrity check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_csr_staged #(
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter logic [Width-1:0] WriteMask  = '1,
    parameter bit               ShadowCopy = 1'b1,
    parameter bit               TwoPhase   = 1'b1,
    parameter bit               Lockable   = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ibex_csr_staged_if.slave   bus
);

    localparam logic [1:0] OpSet   = 2'b01;
    localparam logic [1:0] OpClear = 2'b10;
    localparam logic [1:0] OpRsvd  = 2'b11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STAGED = 1'b1
    } state_e;

    logic [Width-1:0] rdata_q;
    logic [Width-1:0] shadow_q;
    logic [Width-1:0] staged_q;
    logic [Width-1:0] base_d;
    logic [Width-1:0] nv_d;
    state_e           state_q;
    logic             locked_q;
    logic             commit_q;
    logic             update_err_q;
    logic             lock_req;
    logic             valid_req;
    logic             commit_d;
    logic             mismatch_d;
    logic             rd_error;

    // Set/clear always operate on the committed value, never the staged one.
    always_comb begin
        base_d = bus.wr_data_i;
        case (bus.wr_op_i)
            OpSet:   base_d = rdata_q | bus.wr_data_i;
            OpClear: base_d = rdata_q & ~bus.wr_data_i;
            default: base_d = bus.wr_data_i;
        endcase
        nv_d = (base_d & WriteMask) | (ResetValue & ~WriteMask);
    end

    assign lock_req   = Lockable & bus.lock_i;
    assign valid_req  = bus.wr_en_i & (bus.wr_op_i != OpRsvd) & ~locked_q
                      & ~bus.abort_i & ~lock_req;
    assign commit_d   = TwoPhase ? (valid_req & (state_q == STAGED) & (nv_d == staged_q))
                                 : valid_req;
    assign mismatch_d = TwoPhase & valid_req & (state_q == STAGED) & (nv_d != staged_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q      <= ResetValue;
            locked_q     <= 1'b0;
            commit_q     <= 1'b0;
            update_err_q <= 1'b0;
        end else begin
            commit_q     <= commit_d;
            update_err_q <= mismatch_d;
            if (commit_d) begin
                rdata_q <= nv_d;
            end
            if (lock_req) begin
                locked_q <= 1'b1;
            end
        end
    end

    generate
        if (TwoPhase) begin : g_fsm
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_q  <= IDLE;
                    staged_q <= '0;
                end else if (lock_req) begin
                    state_q <= IDLE;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (valid_req) begin
                                staged_q <= nv_d;
                                state_q  <= STAGED;
                            end
                        end
                        STAGED: begin
                            // Confirm or mismatch both end the stage; a
                            // mismatching value is dropped, not re-staged.
                            if (bus.abort_i || valid_req) begin
                                state_q <= IDLE;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end else begin : g_no_fsm
            assign state_q  = IDLE;
            assign staged_q = '0;
        end
    endgenerate

    generate
        if (ShadowCopy) begin : g_shadow
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    shadow_q <= ~ResetValue;
                end else if (commit_d) begin
                    shadow_q <= ~nv_d;
                end
            end
            assign rd_error = (rdata_q != ~shadow_q);
        end else begin : g_no_shadow
            assign shadow_q = ~rdata_q;
            assign rd_error = 1'b0;
        end
    endgenerate

    assign bus.rd_data_o    = rdata_q;
    assign bus.staged_o     = (state_q == STAGED);
    assign bus.locked_o     = locked_q;
    assign bus.commit_o     = commit_q;
    assign bus.update_err_o = update_err_q;
    assign bus.rd_error_o   = rd_error;

endmodule

`default_nettype wire

// File: tb/tb_ibex_csr_staged.sv
// ============================================================================
// Module      : tb_ibex_csr_staged
// Description : Directed vector bench for ibex_csr_staged (two-phase/lockable
//               and single-phase instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_csr_staged;

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic [31:0] data;
        logic        abort;
        logic        lock;
        logic [31:0] rd;
        logic        st;
        logic        lk;
        logic        cm;
        logic        er;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    ibex_csr_staged_if #(.Width(32)) bus0 ();
    ibex_csr_staged_if #(.Width(32)) bus1 ();

    ibex_csr_staged #(
        .Width(32), .ResetValue(32'h10), .WriteMask(32'hFF),
        .ShadowCopy(1'b1), .TwoPhase(1'b1), .Lockable(1'b1)
    ) dut0 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus0)
    );

    ibex_csr_staged #(
        .Width(32), .ResetValue(32'h10), .WriteMask(32'hFF),
        .ShadowCopy(1'b1), .TwoPhase(1'b0), .Lockable(1'b0)
    ) dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] op, input logic [31:0] data,
                       input logic abort, input logic lock, input logic [31:0] rd,
                       input logic st, input logic lk, input logic cm, input logic er);
        vec_t v;
        v.we = we; v.op = op; v.data = data; v.abort = abort; v.lock = lock;
        v.rd = rd; v.st = st; v.lk = lk; v.cm = cm; v.er = er;
        vq.push_back(v);
    endtask

    task automatic drive0(input logic we, input logic [1:0] op, input logic [31:0] data,
                          input logic abort, input logic lock);
        bus0.wr_en_i = we; bus0.wr_op_i = op; bus0.wr_data_i = data;
        bus0.abort_i = abort; bus0.lock_i = lock;
    endtask

    task automatic drive1(input logic we, input logic [1:0] op, input logic [31:0] data);
        bus1.wr_en_i = we; bus1.wr_op_i = op; bus1.wr_data_i = data;
        bus1.abort_i = 1'b0; bus1.lock_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive0(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        drive1(1'b0, 2'b00, 32'h0);
    endtask

    task automatic chk0_all(input string tag, input logic [31:0] rd, input logic st,
                            input logic lk, input logic cm, input logic er, input logic re);
        chk({tag, " rd_data"},    bus0.rd_data_o,           rd);
        chk({tag, " staged"},     {31'b0, bus0.staged_o},     {31'b0, st});
        chk({tag, " locked"},     {31'b0, bus0.locked_o},     {31'b0, lk});
        chk({tag, " commit"},     {31'b0, bus0.commit_o},     {31'b0, cm});
        chk({tag, " update_err"}, {31'b0, bus0.update_err_o}, {31'b0, er});
        chk({tag, " rd_error"},   {31'b0, bus0.rd_error_o},   {31'b0, re});
    endtask

    initial begin
        drive0(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        drive1(1'b0, 2'b00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk0_all("reset", 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset dut1 rd_data", bus1.rd_data_o, 32'h10);
        rst_n = 1'b1;

        //   we  op     data          ab  lk   rd            st  lk  cm  er
        add(1, 2'b00, 32'h55,        0, 0,  32'h10,       1,  0,  0,  0);
        add(1, 2'b00, 32'h56,        0, 0,  32'h10,       0,  0,  0,  1);
        add(0, 2'b00, 32'h0,         0, 0,  32'h10,       0,  0,  0,  0);
        add(1, 2'b00, 32'h56,        0, 0,  32'h10,       1,  0,  0,  0);
        add(0, 2'b00, 32'h0,         1, 0,  32'h10,       0,  0,  0,  0);
        add(1, 2'b00, 32'hABCD_1234, 0, 0,  32'h10,       1,  0,  0,  0);
        add(0, 2'b00, 32'h0,         0, 0,  32'h10,       1,  0,  0,  0);
        add(1, 2'b00, 32'hABCD_1234, 0, 0,  32'h34,       0,  0,  1,  0);
        add(0, 2'b00, 32'h0,         0, 0,  32'h34,       0,  0,  0,  0);
        add(1, 2'b01, 32'h03,        0, 0,  32'h34,       1,  0,  0,  0);
        add(1, 2'b11, 32'hFF,        0, 0,  32'h34,       1,  0,  0,  0);
        add(1, 2'b01, 32'h03,        0, 0,  32'h37,       0,  0,  1,  0);
        add(1, 2'b10, 32'h30,        0, 0,  32'h37,       1,  0,  0,  0);
        add(1, 2'b10, 32'h30,        0, 0,  32'h07,       0,  0,  1,  0);
        add(1, 2'b00, 32'h99,        0, 0,  32'h07,       1,  0,  0,  0);
        add(1, 2'b00, 32'h99,        1, 0,  32'h07,       0,  0,  0,  0);
        add(1, 2'b00, 32'h99,        0, 0,  32'h07,       1,  0,  0,  0);
        add(1, 2'b00, 32'h99,        0, 1,  32'h07,       0,  1,  0,  0);
        add(1, 2'b00, 32'hAA,        0, 0,  32'h07,       0,  1,  0,  0);
        add(1, 2'b00, 32'hAA,        0, 0,  32'h07,       0,  1,  0,  0);
        add(1, 2'b01, 32'hF0,        0, 1,  32'h07,       0,  1,  0,  0);

        foreach (vq[i]) begin
            drive0(vq[i].we, vq[i].op, vq[i].data, vq[i].abort, vq[i].lock);
            step();
            chk0_all($sformatf("vec%0d", i), vq[i].rd, vq[i].st, vq[i].lk, vq[i].cm, vq[i].er, 1'b0);
        end

        // Single-phase instance: one write commits, reserved op is inert.
        drive1(1'b1, 2'b00, 32'hFF);
        step();
        chk("tp0 write rd_data", bus1.rd_data_o, 32'hFF);
        chk("tp0 write commit", {31'b0, bus1.commit_o}, 32'h1);
        chk("tp0 write staged", {31'b0, bus1.staged_o}, 32'h0);
        step();
        chk("tp0 idle commit", {31'b0, bus1.commit_o}, 32'h0);
        drive1(1'b1, 2'b11, 32'h0);
        step();
        chk("tp0 rsvd rd_data", bus1.rd_data_o, 32'hFF);
        chk("tp0 rsvd commit", {31'b0, bus1.commit_o}, 32'h0);

        // Shadow corruption is flagged immediately and cleared by a commit.
        force dut1.shadow_q = 32'hFFFF_FF01;
        #1;
        chk("shadow fault rd_error", {31'b0, bus1.rd_error_o}, 32'h1);
        release dut1.shadow_q;
        drive1(1'b1, 2'b00, 32'h12);
        step();
        chk("shadow rewrite rd_data", bus1.rd_data_o, 32'h12);
        chk("shadow rewrite rd_error", {31'b0, bus1.rd_error_o}, 32'h0);
        chk("shadow rewrite commit", {31'b0, bus1.commit_o}, 32'h1);

        // Reset clears the lock; then reset again while a value is staged.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk("unlock locked", {31'b0, bus0.locked_o}, 32'h0);
        drive0(1'b1, 2'b00, 32'h42, 1'b0, 1'b0);
        step();
        chk("prestage staged", {31'b0, bus0.staged_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk0_all("midreset", 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive0(1'b1, 2'b00, 32'h42, 1'b0, 1'b0);
        step();
        chk0_all("restage", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive0(1'b1, 2'b00, 32'h42, 1'b0, 1'b0);
        step();
        chk0_all("reconfirm", 32'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
